// File: rtl/leiwand_rv32_bus_master.sv
// leiwand_rv32_bus_master: single-transfer stall/ack bus initiator
// with request checking, read lane extraction and timeout abort.
module leiwand_rv32_bus_master #(
  parameter int MEM_WIDTH = 32,
  parameter int TIMEOUT   = 255
) (
  input  logic                 i_clk,
  input  logic                 i_rst,
  input  logic                 i_req,
  input  logic                 i_we,
  input  logic [MEM_WIDTH-1:0] i_addr,
  input  logic [MEM_WIDTH-1:0] i_wdat,
  input  logic [2:0]           i_size,
  input  logic                 i_unsigned,
  output logic                 o_busy,
  output logic                 o_done,
  output logic                 o_err,
  output logic [MEM_WIDTH-1:0] o_rdat,
  output logic                 o_wb_cyc,
  output logic                 o_wb_stb,
  output logic                 o_wb_we,
  output logic [MEM_WIDTH-1:0] o_wb_addr,
  output logic [MEM_WIDTH-1:0] o_wb_dat,
  output logic [2:0]           o_wb_wr_size,
  input  logic [MEM_WIDTH-1:0] i_wb_dat,
  input  logic                 i_wb_ack,
  input  logic                 i_wb_stall
);

  localparam int CW = $clog2(TIMEOUT + 1);

  typedef enum logic [1:0] {
    IDLE,
    ARB,
    ISSUE,
    WAIT
  } state_t;

  state_t         st;
  state_t         nxt;
  logic [CW-1:0]  cnt;
  logic           uns_q;
  logic           bad;
  logic           hit;
  logic           start;
  logic           done_n;
  logic           err_n;
  logic [7:0]     b;
  logic [15:0]    h;
  logic [MEM_WIDTH-1:0] rd;

  assign bad = !(i_size == 3'd1 || i_size == 3'd2 ||
                 i_size == 3'd4) ||
               (i_size == 3'd2 && i_addr[0]) ||
               (i_size == 3'd4 && i_addr[1:0] != 2'b00);
  assign hit   = cnt == CW'(TIMEOUT - 1);
  assign start = st == IDLE && i_req && !bad;

  always_ff @(posedge i_clk or negedge i_rst) begin
    if (!i_rst) st <= IDLE;
    else        st <= nxt;
  end

  // Ack beats timeout when both land in the same WAIT cycle.
  always_comb begin
    nxt    = st;
    done_n = 1'b0;
    err_n  = 1'b0;
    unique case (st)
      IDLE: begin
        if (i_req) begin
          if (bad) err_n = 1'b1;
          else     nxt   = ARB;
        end
      end
      ARB: begin
        if (hit) begin
          nxt   = IDLE;
          err_n = 1'b1;
        end else if (!i_wb_stall) begin
          nxt = ISSUE;
        end
      end
      ISSUE: nxt = WAIT;
      WAIT: begin
        if (i_wb_ack) begin
          nxt    = IDLE;
          done_n = 1'b1;
        end else if (hit) begin
          nxt   = IDLE;
          err_n = 1'b1;
        end
      end
      default: nxt = IDLE;
    endcase
  end

  always_ff @(posedge i_clk or negedge i_rst) begin
    if (!i_rst) begin
      cnt <= '0;
    end else if (start) begin
      cnt <= '0;
    end else if (st == ARB || st == WAIT) begin
      cnt <= cnt + 1'b1;
    end
  end

  assign b = i_wb_dat[{o_wb_addr[1:0], 3'b000} +: 8];
  assign h = i_wb_dat[{o_wb_addr[1], 4'b0000} +: 16];

  always_comb begin
    rd = i_wb_dat;
    unique case (1'b1)
      o_wb_wr_size == 3'd1:
        rd = {{(MEM_WIDTH-8){b[7] & ~uns_q}}, b};
      o_wb_wr_size == 3'd2:
        rd = {{(MEM_WIDTH-16){h[15] & ~uns_q}}, h};
      default: rd = i_wb_dat;
    endcase
  end

  always_ff @(posedge i_clk or negedge i_rst) begin
    if (!i_rst) begin
      o_wb_addr    <= '0;
      o_wb_dat     <= '0;
      o_wb_we      <= 1'b0;
      o_wb_wr_size <= 3'd0;
      uns_q        <= 1'b0;
      o_rdat       <= '0;
    end else begin
      if (st == IDLE && i_req) begin
        o_wb_addr    <= i_addr;
        o_wb_dat     <= i_wdat;
        o_wb_we      <= i_we;
        o_wb_wr_size <= i_size;
        uns_q        <= i_unsigned;
      end
      if (done_n && !o_wb_we) o_rdat <= rd;
    end
  end

  always_ff @(posedge i_clk or negedge i_rst) begin
    if (!i_rst) begin
      o_busy   <= 1'b0;
      o_wb_cyc <= 1'b0;
      o_wb_stb <= 1'b0;
      o_done   <= 1'b0;
      o_err    <= 1'b0;
    end else begin
      o_busy   <= nxt != IDLE;
      o_wb_cyc <= nxt != IDLE;
      o_wb_stb <= nxt == ISSUE;
      o_done   <= done_n;
      o_err    <= err_n;
    end
  end

endmodule

// File: tb/tb_leiwand_rv32_bus_master.sv
// tb_leiwand_rv32_bus_master: directed loads/stores against a small
// RAM responder, expectations queued and checked by a pulse monitor.
module tb_leiwand_rv32_bus_master;

  logic        clk;
  logic        rst;
  logic        req;
  logic        we;
  logic [31:0] addr;
  logic [31:0] wdat;
  logic [2:0]  size;
  logic        uns;
  logic        busy;
  logic        done;
  logic        err;
  logic [31:0] rdat;
  logic        cyc;
  logic        stb;
  logic        bwe;
  logic [31:0] baddr;
  logic [31:0] bdat;
  logic [2:0]  bsize;
  logic [31:0] bus_rd;
  logic        ack;
  logic        stall;
  logic        ack_en;

  leiwand_rv32_bus_master #(
    .MEM_WIDTH(32),
    .TIMEOUT  (8)
  ) dut (
    .i_clk       (clk),
    .i_rst       (rst),
    .i_req       (req),
    .i_we        (we),
    .i_addr      (addr),
    .i_wdat      (wdat),
    .i_size      (size),
    .i_unsigned  (uns),
    .o_busy      (busy),
    .o_done      (done),
    .o_err       (err),
    .o_rdat      (rdat),
    .o_wb_cyc    (cyc),
    .o_wb_stb    (stb),
    .o_wb_we     (bwe),
    .o_wb_addr   (baddr),
    .o_wb_dat    (bdat),
    .o_wb_wr_size(bsize),
    .i_wb_dat    (bus_rd),
    .i_wb_ack    (ack),
    .i_wb_stall  (stall)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Responder: acks two edges after it samples stb.
  logic [31:0] mem [16];
  logic        pend;
  logic [31:0] paddr;

  always @(posedge clk) begin
    if (!rst) begin
      for (int i = 0; i < 16; i++) mem[i] <= 32'h0;
      mem[3] <= 32'h8000_00F1;
      mem[4] <= 32'h1122_3344;
      mem[5] <= 32'h80F1_7F82;
      pend   <= 1'b0;
      ack    <= 1'b0;
      bus_rd <= 32'h0;
    end else begin
      pend <= cyc && stb;
      if (cyc && stb) begin
        paddr <= baddr;
        if (bwe) begin
          if (bsize == 3'd1)
            mem[baddr[5:2]][{baddr[1:0], 3'b000} +: 8] <= bdat[7:0];
          else if (bsize == 3'd2)
            mem[baddr[5:2]][{baddr[1], 4'b0000} +: 16] <= bdat[15:0];
          else
            mem[baddr[5:2]] <= bdat;
        end
      end
      ack    <= pend && ack_en;
      bus_rd <= mem[paddr[5:2]];
    end
  end

  int cyc_no;
  always @(posedge clk) cyc_no <= cyc_no + 1;

  typedef struct {
    logic        is_err;
    logic [31:0] rdat;
  } exp_t;

  exp_t sb[$];
  int   tests;
  int   fails;
  int   cyc_rises;
  int   stb_cycles;
  int   stb_rise_at;
  logic cyc_prev;
  logic stb_prev;

  task automatic chk(input string nm, input logic [31:0] act,
                     input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  always @(negedge clk) begin
    exp_t e;
    if (done || err) begin
      if (sb.size() == 0) begin
        tests++;
        fails++;
        $display("FAIL unexpected_pulse: done=%b err=%b", done, err);
      end else begin
        e = sb.pop_front();
        chk("pulse_kind", {30'b0, err, done},
            {30'b0, e.is_err, ~e.is_err});
        chk("rdat", rdat, e.rdat);
      end
    end
    if (cyc && !cyc_prev) cyc_rises++;
    if (stb) begin
      stb_cycles++;
      if (!stb_prev) stb_rise_at = cyc_no;
    end
    cyc_prev = cyc;
    stb_prev = stb;
  end

  // Call #1 after a posedge; returns edges from request to pulse.
  task automatic xfer(input logic w, input logic [31:0] a,
                      input logic [31:0] d, input logic [2:0] s,
                      input logic u, input logic e_err,
                      input logic [31:0] e_rdat,
                      output int lat, output int k);
    exp_t e;
    e.is_err = e_err;
    e.rdat   = e_rdat;
    sb.push_back(e);
    req  = 1'b1;
    we   = w;
    addr = a;
    wdat = d;
    size = s;
    uns  = u;
    @(posedge clk);
    #1;
    k   = cyc_no;
    req = 1'b0;
    lat = -1;
    for (int n = 0; n <= 40; n++) begin
      if (done || err) begin
        lat = n;
        break;
      end
      @(posedge clk);
      #1;
    end
    if (lat < 0) begin
      tests++;
      fails++;
      $display("FAIL no_response: addr %h", a);
    end
  endtask

  int lat;
  int k;
  int snap;

  initial begin
    cyc_no      = 0;
    tests       = 0;
    fails       = 0;
    cyc_rises   = 0;
    stb_cycles  = 0;
    stb_rise_at = 0;
    cyc_prev    = 1'b0;
    stb_prev    = 1'b0;
    rst    = 1'b0;
    req    = 1'b0;
    we     = 1'b0;
    addr   = 32'h0;
    wdat   = 32'h0;
    size   = 3'd0;
    uns    = 1'b0;
    stall  = 1'b0;
    ack_en = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    chk("reset_ctl", {27'b0, busy, done, err, cyc, stb}, 32'h0);
    chk("reset_rdat", rdat, 32'h0);
    chk("reset_bus", baddr | bdat | {29'b0, bsize} | {31'b0, bwe},
        32'h0);
    rst = 1'b1;
    @(posedge clk);
    #1;

    snap = stb_cycles;
    xfer(0, 32'h0C, 0, 3'd4, 0, 0, 32'h8000_00F1, lat, k);
    chk("word_lat", 32'(lat), 32'd4);
    chk("word_stb_cycles", 32'(stb_cycles - snap), 32'd1);
    chk("word_stb_at", 32'(stb_rise_at - k), 32'd1);
    chk("word_cyc_low", {31'b0, cyc}, 32'h0);

    xfer(0, 32'h15, 0, 3'd1, 0, 0, 32'h0000_007F, lat, k);
    xfer(0, 32'h14, 0, 3'd1, 0, 0, 32'hFFFF_FF82, lat, k);
    xfer(0, 32'h16, 0, 3'd2, 0, 0, 32'hFFFF_80F1, lat, k);
    xfer(0, 32'h16, 0, 3'd2, 1, 0, 32'h0000_80F1, lat, k);
    chk("back_to_back_lat", 32'(lat), 32'd4);

    xfer(1, 32'h13, 32'hAB, 3'd1, 0, 0, 32'h0000_80F1, lat, k);
    chk("store_wb_dat", bdat, 32'h0000_00AB);
    xfer(0, 32'h10, 0, 3'd4, 0, 0, 32'hAB22_3344, lat, k);

    snap = cyc_rises;
    xfer(0, 32'h02, 0, 3'd4, 0, 1, 32'hAB22_3344, lat, k);
    chk("misalign_lat", 32'(lat), 32'd0);
    xfer(0, 32'h00, 0, 3'd3, 0, 1, 32'hAB22_3344, lat, k);
    chk("size3_lat", 32'(lat), 32'd0);
    xfer(0, 32'h01, 0, 3'd2, 0, 1, 32'hAB22_3344, lat, k);
    chk("reject_no_cyc", 32'(cyc_rises - snap), 32'd0);
    chk("reject_busy", {31'b0, busy}, 32'h0);

    ack_en = 1'b0;
    xfer(0, 32'h0C, 0, 3'd4, 0, 1, 32'hAB22_3344, lat, k);
    chk("timeout_lat", 32'(lat), 32'd9);
    chk("timeout_cyc", {31'b0, cyc}, 32'h0);
    ack_en = 1'b1;
    xfer(0, 32'h0C, 0, 3'd4, 0, 0, 32'h8000_00F1, lat, k);
    chk("post_timeout_lat", 32'(lat), 32'd4);

    stall = 1'b1;
    fork
      xfer(0, 32'h14, 0, 3'd4, 0, 0, 32'h80F1_7F82, lat, k);
      begin
        repeat (4) @(posedge clk);
        #1;
        stall = 1'b0;
      end
    join
    chk("stall_stb_at", 32'(stb_rise_at - k), 32'd4);
    chk("stall_lat", 32'(lat), 32'd7);

    req  = 1'b1;
    we   = 1'b0;
    addr = 32'h0C;
    size = 3'd4;
    @(posedge clk);
    #1;
    req = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    chk("mid_cyc_before", {31'b0, cyc}, 32'h1);
    #1;
    rst = 1'b0;
    #1;
    chk("mid_reset_ctl", {29'b0, cyc, stb, busy}, 32'h0);
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b1;
    @(posedge clk);
    #1;
    chk("mid_reset_rdat", rdat, 32'h0);
    xfer(0, 32'h0C, 0, 3'd4, 0, 0, 32'h8000_00F1, lat, k);
    chk("post_reset_lat", 32'(lat), 32'd4);

    repeat (3) @(posedge clk);
    #1;
    chk("sb_drained", 32'(sb.size()), 32'd0);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/leiwand_rv32_bus_master.md
# leiwand_rv32_bus_master

Single-transfer bus initiator that turns CPU load/store requests into transactions on the core's stall/ack memory bus. It drives the bus from the initiator side, with `leiwand_rv32_ram`-style responders on the other end. It extracts byte and halfword lanes from read data and applies sign or zero extension. It also rejects misaligned or illegal-size requests and aborts transfers that exceed a timeout.

## Interface
- `MEM_WIDTH`, default 32: address and data width.
- `TIMEOUT`, default 255: maximum cycles in ARB plus WAIT before an abort. Counter width is `HIGH_BIT_TO_FIT(TIMEOUT)+1`.

Ports:
- `i_clk`  in  1  — the single clock.
- `i_rst`  in  1  — asynchronous, active-low reset.
- `i_req`  in  1  — start a request. Sampled only in IDLE.
- `i_we`  in  1  — 1 = store, 0 = load.
- `i_addr`  in  MEM_WIDTH  — byte address.
- `i_wdat`  in  MEM_WIDTH  — store data, LSB-aligned (not lane-shifted).
- `i_size`  in  3  — transfer size in bytes: 1, 2 or 4.
- `i_unsigned`  in  1  — load extension: 1 = zero-extend, 0 = sign-extend.
- `o_busy`  out  1  — high whenever state ≠ IDLE.
- `o_done`  out  1  — one-cycle pulse on successful completion.
- `o_err`  out  1  — one-cycle pulse on misalign, illegal size or timeout.
- `o_rdat`  out  MEM_WIDTH  — extended load result. Valid with `o_done`, held until the next `o_done`.
- `o_wb_cyc`, `o_wb_stb`, `o_wb_we`  out  1 each  — bus control.
- `o_wb_addr`  out  MEM_WIDTH  — bus address.
- `o_wb_dat`  out  MEM_WIDTH  — bus write data.
- `o_wb_wr_size`  out  3  — bus transfer size.
- `i_wb_dat`  in  MEM_WIDTH  — bus read data.
- `i_wb_ack`, `i_wb_stall`  in  1 each  — bus handshake.

## Operation
- **State machine:** IDLE, ARB, ISSUE, WAIT.
- **IDLE, on `i_req`:** capture `i_we`, `i_addr`, `i_wdat`, `i_size`, `i_unsigned`, then check the request.
  - Illegal size (0, 3, 5, 6, 7) → `o_err` next cycle, no bus activity, stay IDLE.
  - Misaligned (size 2 with `addr[0]`=1, or size 4 with `addr[1:0]`≠0) → `o_err` next cycle, no bus activity, stay IDLE.
  - Otherwise go to ARB and raise `o_wb_cyc`.
- **ARB:** `o_wb_cyc`=1, `o_wb_stb`=0.
  - If `i_wb_stall`=0 → ISSUE.
  - Otherwise keep waiting. This covers a responder still initialising.
- **ISSUE:** `o_wb_stb`=1 for exactly one cycle, then go to WAIT. Ignore `i_wb_stall` here, because the responder may assert it combinationally on `stb`.
- **WAIT:** `o_wb_cyc`=1, `o_wb_stb`=0.
  - On `i_wb_ack`=1: clear `o_wb_cyc`, pulse `o_done`, and load `o_rdat` (loads only; stores leave `o_rdat` unchanged). Then go to IDLE.
- **Held outputs:** `o_wb_addr`, `o_wb_we`, `o_wb_dat`, `o_wb_wr_size` hold the captured values from entering ARB until return to IDLE. The responder samples them throughout.
- **Read lane extraction** (loads):
  - Size 1: byte `addr[1:0]`×8 of `i_wb_dat`, extended from bit 7.
  - Size 2: halfword `addr[1]`×16 of `i_wb_dat`, extended from bit 15.
  - Size 4: the full word.
- **Ignored inputs:** `i_wb_ack` is ignored in IDLE, ARB and ISSUE. `i_req` is ignored while `o_busy`=1.
- **Timeout:** the counter clears on entering ARB and increments every cycle in ARB and WAIT.
  - On reaching `TIMEOUT` without an ack: drop `cyc`/`stb`, pulse `o_err`, go to IDLE, leave `o_rdat` unchanged.
  - If ack and timeout land in the same cycle, the ack wins.

## Timing
- **Reset (`i_rst`=0, asynchronous):** state IDLE, counter 0. `o_busy`, `o_done`, `o_err`, `o_wb_cyc`, `o_wb_stb`, `o_wb_we` = 0; `o_rdat`, `o_wb_addr`, `o_wb_dat` = 0; `o_wb_wr_size` = 0.
- **Reset mid-transfer:** outputs clear immediately, no `o_done`/`o_err` is produced, and the transfer is lost.
- **All outputs are registered.**
- **Cycle budget against the team RAM**, with `i_req` sampled at edge k:
  - edge k+1: ARB (`cyc`=1);
  - edge k+2: ISSUE (`stb`=1);
  - edge k+3: WAIT (`stb`=0);
  - responder ack seen at edge k+4;
  - `o_done` high in the cycle after edge k+4, with `cyc`=0.
- **Back-to-back:** a new `i_req` is accepted in the cycle `o_done` is high, so the minimum spacing between `o_done` pulses is 5 cycles.
- **Error pulses:** the misalign/illegal-size `o_err` is high in the cycle after edge k, with `o_busy` never set.

## Test plan
- **Word load:** RAM word 3 = 0x8000_00F1; load size 4, addr 0x0C → `o_rdat`=0x8000_00F1, `o_done` 4 edges after the request, exactly one `stb` cycle.
- **Byte and halfword loads** from word 0x80F1_7F82:
  - byte signed, addr+1 → 0x0000_007F;
  - byte signed, addr+0 → 0xFFFF_FF82;
  - half signed, addr+2 → 0xFFFF_80F1;
  - half unsigned, addr+2 → 0x0000_80F1.
- **Store byte:** 0xAB at addr 0x13 (size 1), then word load at 0x10 → bits 31:24 = 0xAB, other bytes unchanged; `o_wb_dat`=0x0000_00AB held through the ack.
- **Rejected requests:** misaligned (size 4 at 0x02) or size 3 → `o_err` one cycle, `o_wb_cyc` never rises, `o_rdat` unchanged.
- **Timeout and stall:**
  - responder never acks, `TIMEOUT`=8 → `o_err` 8 cycles after ARB entry, `cyc`=0, next request serviced normally;
  - `i_wb_stall` held high 3 cycles after reset → `stb` delayed exactly 3 cycles.
- **Reset mid-transfer:** assert `i_rst`=0 during WAIT → `cyc`/`stb`/`busy` = 0 asynchronously, no `o_done`, and a clean transfer after release.
